// File: rtl/raster_bound_counter.sv
// raster_bound_counter
// N_CH nested coordinate counters advanced as a raster scan (channel 0 is the
// innermost, X). Each channel has its own limit and stride register. Outputs
// per-channel "count < limit" flags, registered wrap pulses and a frame-done
// pulse. All state changes on the falling clock edge; reset is asynchronous,
// active low.
module raster_bound_counter #(
  parameter int          N_CH       = 2,
  parameter int          W          = 16,
  parameter int unsigned DEF_LIMIT  = 128,
  parameter int unsigned DEF_STRIDE = 1,
  localparam int         CHW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [W-1:0]      data_in,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [1:0]        wr_field,
  input  logic              step_en,
  input  logic              clr,
  output logic [N_CH*W-1:0] count,
  output logic [N_CH-1:0]   flag,
  output logic [N_CH-1:0]   wrap,
  output logic              done
);

  // Write-field encodings; 3 is reserved and matches none of these.
  localparam logic [1:0] FIELD_LIMIT  = 2'd0;
  localparam logic [1:0] FIELD_STRIDE = 2'd1;
  localparam logic [1:0] FIELD_COUNT  = 2'd2;

  // Per-channel register file
  logic [W-1:0] cnt_q [N_CH];
  logic [W-1:0] cnt_d [N_CH];
  logic [W-1:0] lim_q [N_CH];
  logic [W-1:0] lim_d [N_CH];
  logic [W-1:0] str_q [N_CH];
  logic [W-1:0] str_d [N_CH];

  logic [N_CH-1:0] wrap_q;
  logic [N_CH-1:0] wrap_d;
  logic            done_q;
  logic            done_d;

  // Step datapath results (before clr / preload overrides)
  logic [W:0]      sum      [N_CH];
  logic [W-1:0]    step_cnt [N_CH];
  logic [N_CH-1:0] step_wrap;
  logic            step_done;

  // Decoded write strobes per channel. A write to a channel index that does
  // not exist simply matches no channel.
  logic [N_CH-1:0] hit_lim;
  logic [N_CH-1:0] hit_str;
  logic [N_CH-1:0] hit_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W-1:0] eff_stride;
      logic         sel;

      // A zero stride would freeze the scan, so it behaves as stride 1.
      assign eff_stride = (str_q[gi] == '0) ? W'(1) : str_q[gi];

      // One extra bit so a sum past 2^W-1 still compares as >= limit.
      assign sum[gi] = {1'b0, cnt_q[gi]} + {1'b0, eff_stride};

      assign sel         = wr_en && (wr_ch == CHW'(gi));
      assign hit_lim[gi] = sel && (wr_field == FIELD_LIMIT);
      assign hit_str[gi] = sel && (wr_field == FIELD_STRIDE);
      assign hit_cnt[gi] = sel && (wr_field == FIELD_COUNT);

      assign count[gi*W +: W] = cnt_q[gi];
      assign flag[gi]         = (cnt_q[gi] < lim_q[gi]);
    end
  endgenerate

  assign wrap = wrap_q;
  assign done = done_q;

  // Ripple the step carry from the innermost channel outwards.
  always_comb begin : step_chain
    logic carry;
    carry     = step_en;
    step_wrap = '0;
    for (int k = 0; k < N_CH; k++) begin
      step_cnt[k] = cnt_q[k];
      if (carry) begin
        if (sum[k] >= {1'b0, lim_q[k]}) begin
          step_cnt[k]  = '0;
          step_wrap[k] = 1'b1;
        end else begin
          step_cnt[k] = sum[k][W-1:0];
          carry       = 1'b0;
        end
      end
    end
    step_done = carry;
  end

  // Apply clr, preload and limit/stride writes on top of the step result.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cnt_d[k] = step_cnt[k];
      lim_d[k] = lim_q[k];
      str_d[k] = str_q[k];
      // Limit/stride writes land even during clr; the step already used the
      // old register value, so the new value only matters from the next edge.
      if (hit_lim[k]) begin
        lim_d[k] = data_in;
      end
      if (hit_str[k]) begin
        str_d[k] = data_in;
      end
      // clr wins over everything; a preload replaces only this channel's
      // count, leaving the carry and wrap of the step untouched.
      if (clr) begin
        cnt_d[k] = '0;
      end else if (hit_cnt[k]) begin
        cnt_d[k] = data_in;
      end
    end
    wrap_d = clr ? '0 : step_wrap;
    done_d = clr ? 1'b0 : step_done;
  end

  // State register, updated on the falling edge with async active-low reset.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= '0;
        lim_q[k] <= W'(DEF_LIMIT);
        str_q[k] <= W'(DEF_STRIDE);
      end
      wrap_q <= '0;
      done_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
        lim_q[k] <= lim_d[k];
        str_q[k] <= str_d[k];
      end
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

endmodule

// File: doc/raster_bound_counter.md
Name: raster_bound_counter

Overview:
- Parametrised successor to the processor's X/Y bound-flag logic.
- Holds N_CH nested coordinate counters, each with its own programmable limit and stride register, and advances them as a raster scan. Channel 0 is innermost (X), channel 1 is next (Y), and so on.
- Produces per-channel "count < limit" flags, per-channel wrap pulses and a frame-done pulse.
- Sits beside the X/Y registers and feeds the control unit's branch/loop decisions for image downsampling.

Parameters:
- N_CH, 2, number of nested counter channels (1..8).
- W, 16, width of counters, limits, strides and data_in.
- DEF_LIMIT, 128, reset value of every limit register.
- DEF_STRIDE, 1, reset value of every stride register.

Ports:
- clock  in  1  system clock; all state updates on the falling edge.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  W  immediate data from the instruction.
- wr_en  in  1  register write strobe.
- wr_ch  in  max(1,$clog2(N_CH))  target channel of the write.
- wr_field  in  2  write target: 0=limit, 1=stride, 2=counter preload, 3=reserved (ignored).
- step_en  in  1  advance the raster by one step.
- clr  in  1  synchronous clear of all counters.
- count  out  N_CH*W  flattened counter values; channel k occupies bits [k*W +: W].
- flag  out  N_CH  flag[k] = count_k < limit_k (unsigned, combinational from registers).
- wrap  out  N_CH  registered one-cycle pulse: channel k wrapped on the last step.
- done  out  1  registered one-cycle pulse: the outermost channel wrapped (frame complete).

Behaviour:
- Reset (async, reset_n=0) sets:
  - all counters to 0;
  - limits to DEF_LIMIT;
  - strides to DEF_STRIDE;
  - wrap and done to 0.
  - flag therefore reads all-ones when DEF_LIMIT>0.
- Deasserting reset mid-operation makes no attempt to resume; the counter chain restarts from 0.
- State updates on the negedge of clock only.
- wrap and done are pulses: each is high for exactly one cycle after the causing step, and is 0 on any edge without a wrapping step.
- Step arithmetic, for each channel k, with carry_in_0 = step_en:
  - eff_stride = stride_k, or 1 when stride_k == 0.
  - sum = count_k + eff_stride, computed in W+1 bits so there is no silent overflow.
  - If carry_in_k = 0: the counter holds.
  - Else if sum >= limit_k: count_k <= 0, wrap_k <= 1, and carry_in_{k+1} = 1.
  - Else: count_k <= sum[W-1:0] and the carry stops.
  - done <= carry out of channel N_CH-1; on that step all counters return to 0.
- limit_k == 0: every step that reaches channel k wraps it and carries; count_k stays 0 and flag[k] = 0.
- A preloaded counter with count_k >= limit_k gives flag[k] = 0; the next step reaching channel k wraps it to 0 with carry.
- Priority, per edge:
  1. clr: all counters <= 0 and wrap/done <= 0; the step is discarded. A limit/stride write on the same edge still takes effect. A counter-preload write on the same edge is discarded.
  2. Counter-preload write to channel k: overrides the step result for channel k only. The carry out of k is still computed from the pre-write value, and wrap_k follows that step computation.
  3. A limit/stride write on the same edge as a step: the step uses the old value; the new value applies from the next edge. flag uses the register contents, so it reflects a new limit one edge after the write.
- wr_field=3, or wr_ch >= N_CH: the write is ignored with no side effects.
- Latency: count, wrap and done are valid after the negedge on which step_en was sampled. flag follows count combinationally.

Test Plan:
- Reset with N_CH=2, W=16 -> count=0/0, flag=2'b11, wrap=0, done=0; limits read 128 via flag transition at count 127->128 blocked by wrap.
- Write limit0=3, limit1=2, then 6 steps -> count0 sequence 1,2,0,1,2,0; count1 sequence 0,0,1,1,1,0; wrap[0] pulses on steps 3 and 6; wrap[1] and done pulse on step 6 only.
- Write stride0=2, limit0=5, then steps -> count0 2,4,0 (sum 6>=5 wraps); stride0=0 -> count0 increments by 1.
- Preload count0=200 with limit0=128 -> flag[0]=0; the next step gives count0=0, wrap[0]=1, count1 +1.
- clr together with step_en and a limit0=9 write -> counters 0, no wrap pulse, limit0=9 takes effect.
- Step_en with a counter-preload of channel 0 to 7 on the same edge, count0=limit0-1 -> count0=7, channel 1 still increments, wrap[0]=1. Assert reset_n low mid-scan -> all outputs clear immediately without a clock edge.
